// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage cache/RAM sequencing controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT_WB,
    RD_REQ,
    FILL
  } state_t;

  function automatic logic [63:0] word_align(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline/cache/RAM-side signal bundle of mem_ctrl; slave is the controller.
interface mem_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             load;
  logic             store;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] store_word;
  logic             cache_hit;
  logic [WIDTH-1:0] ram_rdata;
  logic             ram_ack;
  logic             stall;
  logic             cache_wen;
  logic             cache_fill;
  logic             ram_req;
  logic             ram_we;
  logic [WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] fill_data;
  logic             err;

  modport master (
    output load, store, addr, store_word, cache_hit, ram_rdata, ram_ack,
    input  stall, cache_wen, cache_fill, ram_req, ram_we, ram_addr, ram_wdata,
           fill_data, err
  );

  modport slave (
    input  load, store, addr, store_word, cache_hit, ram_rdata, ram_ack,
    output stall, cache_wen, cache_fill, ram_req, ram_we, ram_addr, ram_wdata,
           fill_data, err
  );
endinterface

// File: rtl/mem_wbuf.sv
// One-entry store buffer; an accept on the drain-ack edge reloads instead of clearing.
module mem_wbuf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [WIDTH-1:0] accept_addr,
  input  logic [WIDTH-1:0] accept_data,
  input  logic             drain_ack,
  output logic             valid,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      addr  <= accept_addr;
      data  <= accept_data;
    end else if (drain_ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Load-miss refill FSM plus write-buffer drain arbitration for the MEM stage.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input logic      clk,
  input logic      rst_n,
  mem_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  state_t           state, state_nx;
  logic             wb_valid;
  logic [WIDTH-1:0] wb_addr, wb_data;
  logic             accept, draining, drain_ack, waiting;
  logic [WIDTH-1:0] addr_al;
  logic [CW-1:0]    wait_cnt;

  assign addr_al = WIDTH'(word_align(64'(bus.addr)));

  mem_wbuf #(.WIDTH(WIDTH)) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .accept_addr(addr_al),
    .accept_data(bus.store_word),
    .drain_ack  (drain_ack),
    .valid      (wb_valid),
    .addr       (wb_addr),
    .data       (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Outputs are gated by rst_n so the strobes and stall are quiet during reset.
  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    bus.stall     = 1'b0;
    bus.cache_wen = 1'b0;
    bus.cache_fill = 1'b0;
    bus.ram_req   = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    draining      = wb_valid && (state == IDLE || state == RD_WAIT_WB);
    drain_ack     = draining && bus.ram_ack;
    if (rst_n) begin
      if (draining) begin
        bus.ram_req   = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = wb_addr;
        bus.ram_wdata = wb_data;
      end
      unique case (state)
        IDLE: begin
          if (bus.store) begin
            if (!wb_valid || drain_ack) begin
              accept        = 1'b1;
              bus.cache_wen = 1'b1;
            end else begin
              bus.stall = 1'b1;
            end
          end else if (bus.load && !bus.cache_hit) begin
            bus.stall = 1'b1;
            // A drain finishing this very cycle lets the read go out next cycle.
            state_nx  = (wb_valid && !drain_ack) ? RD_WAIT_WB : RD_REQ;
          end
        end
        RD_WAIT_WB: begin
          bus.stall = 1'b1;
          if (!wb_valid || drain_ack) state_nx = RD_REQ;
        end
        RD_REQ: begin
          bus.stall    = 1'b1;
          bus.ram_req  = 1'b1;
          bus.ram_we   = 1'b0;
          bus.ram_addr = addr_al;
          if (bus.ram_ack) state_nx = FILL;
        end
        FILL: begin
          bus.stall      = 1'b1;
          bus.cache_wen  = 1'b1;
          bus.cache_fill = 1'b1;
          state_nx       = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign waiting = bus.ram_req && !bus.ram_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fill_data <= '0;
      wait_cnt      <= '0;
      bus.err       <= 1'b0;
    end else begin
      if (state == RD_REQ && bus.ram_ack) bus.fill_data <= bus.ram_rdata;
      if (!waiting)          wait_cnt <= '0;
      else if (wait_cnt != TO) wait_cnt <= wait_cnt + 1'b1;
      if ((TIMEOUT != 0 && waiting && wait_cnt == TO - 1'b1) || (bus.load && bus.store))
        bus.err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus a random load/store mix vs a memory model.
module tb_mem_ctrl;
  localparam int W = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } xact_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  xact_t       log_q[$];
  logic [31:0] ram_mem[1024];
  logic        auto_mode = 1'b0;
  int          lat = 1;
  logic        manual_ack = 1'b0;
  int          stab_viol = 0;

  mem_ctrl_if #(.WIDTH(W)) bus();

  mem_ctrl #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3*W+5:0] outs();
    return {bus.stall, bus.cache_wen, bus.cache_fill, bus.ram_req, bus.ram_we, bus.err,
            bus.ram_addr, bus.ram_wdata, bus.fill_data};
  endfunction

  // RAM responder: ack on the lat-th cycle of a request; also watches request stability.
  initial begin : ram_model
    int          cnt;
    int          cur_lat;
    logic        p_wait, p_we;
    logic [31:0] p_addr, p_wd;
    cnt = 0; cur_lat = 1; p_wait = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
    bus.ram_ack = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.ram_ack = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        p_wait = 1'b0;
      end else begin
        if (p_wait && bus.ram_req &&
            (bus.ram_addr !== p_addr || bus.ram_we !== p_we || (p_we && bus.ram_wdata !== p_wd)))
          stab_viol++;
        if (!auto_mode) bus.ram_ack = manual_ack;
        if (bus.ram_req) begin
          if (auto_mode) begin
            if (cnt == 0) cur_lat = lat;
            cnt++;
            if (cnt >= cur_lat) begin
              bus.ram_ack = 1'b1;
              cnt = 0;
            end
          end
          if (bus.ram_ack) begin
            if (bus.ram_we) ram_mem[bus.ram_addr[11:2]] = bus.ram_wdata;
            else bus.ram_rdata = ram_mem[bus.ram_addr[11:2]];
            log_q.push_back('{we: bus.ram_we, a: bus.ram_addr,
                              d: bus.ram_we ? bus.ram_wdata : bus.ram_rdata});
          end
        end else begin
          cnt = 0;
        end
        p_wait = bus.ram_req && !bus.ram_ack;
        p_addr = bus.ram_addr;
        p_we   = bus.ram_we;
        p_wd   = bus.ram_wdata;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.store = 1'b0; bus.addr = '0; bus.store_word = '0; bus.cache_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one MEM-stage op and holds it until stall is low; a miss load hits after its FILL.
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] d, input logic hit,
                        output int stalls, output logic filled, output logic [31:0] fval,
                        output logic saw_req, output logic hung);
    logic done;
    done = 1'b0; stalls = 0; filled = 1'b0; fval = '0; saw_req = 1'b0;
    @(posedge clk); #1;
    bus.load = (kind == 1); bus.store = (kind == 2);
    bus.addr = a; bus.store_word = d; bus.cache_hit = hit;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.ram_req) saw_req = 1'b1;
      if (bus.cache_wen && bus.cache_fill) begin filled = 1'b1; fval = bus.fill_data; end
      if (!bus.stall) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
        if (filled) bus.cache_hit = 1'b1;
      end
    end
    hung = !done;
  endtask

  task automatic drain(output logic hung);
    hung = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.store = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.ram_req) begin hung = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v100;
    v100 = $urandom;
    ram_mem[10'h40] = v100;
    auto_mode = 1'b0; manual_ack = 1'b0;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.store = 1'b0; bus.addr = '0; bus.store_word = '0; bus.cache_hit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (outs() !== '0) begin bad++; $display("FAIL reset_outs: got %h expected 0", outs()); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.load = 1'b1; bus.addr = 32'h200;
    @(negedge clk);
    total++; if ({bus.stall, bus.ram_req} !== 2'b10) begin bad++;
      $display("FAIL miss_first_cycle: got stall,req=%b expected 10", {bus.stall, bus.ram_req}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.ram_req, bus.ram_we, bus.ram_addr} !== {2'b10, 32'h200}) begin bad++;
      $display("FAIL rd_req: got req,we,addr=%b %b %h expected 1 0 00000200", bus.ram_req, bus.ram_we, bus.ram_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (outs() !== '0) begin bad++; $display("FAIL reset_mid_req: got %h expected 0", outs()); end
    @(posedge clk); #1 bus.load = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; manual_ack = 1'b1;
    @(negedge clk);
    total++; if (outs() !== '0) begin bad++; $display("FAIL late_ack: got %h expected 0", outs()); end
    @(posedge clk); #1 manual_ack = 1'b0;
    @(negedge clk);
    total++; if (outs() !== '0) begin bad++; $display("FAIL after_late_ack: got %h expected 0", outs()); end
    @(posedge clk); #1 bus.load = 1'b1; bus.addr = 32'h100;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.ram_req, bus.ram_we, bus.ram_addr} !== {2'b10, 32'h100}) begin bad++;
      $display("FAIL restart_req: got req,we,addr=%b %b %h expected 1 0 00000100", bus.ram_req, bus.ram_we, bus.ram_addr); end
    manual_ack = 1'b1;
    @(posedge clk); #3 manual_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.cache_wen, bus.cache_fill, bus.fill_data} !== {2'b11, v100}) begin bad++;
      $display("FAIL restart_fill: got wen,fill,data=%b %b %h expected 1 1 %h", bus.cache_wen, bus.cache_fill, bus.fill_data, v100); end
    @(posedge clk); #1 bus.cache_hit = 1'b1;
    @(negedge clk);
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL restart_hit_stall: got %b expected 0", bus.stall); end
    @(posedge clk); #1 bus.load = 1'b0; bus.cache_hit = 1'b0;
  endtask

  task automatic test_load_hit();
    int st; logic f, sr, h; logic [31:0] fv;
    auto_mode = 1'b1; lat = 2;
    run_op(1, 32'h40, 32'h0, 1'b1, st, f, fv, sr, h);
    total++; if ({h, sr, f} !== 3'b000 || st != 0) begin bad++;
      $display("FAIL load_hit: got stalls=%0d req=%b fill=%b hung=%b expected 0 0 0 0", st, sr, f, h); end
  endtask

  task automatic test_load_miss();
    int st; logic f, sr, h; logic [31:0] fv;
    auto_mode = 1'b1; lat = 3;
    ram_mem[32'h44 >> 2] = 32'hDEADBEEF;
    run_op(1, 32'h44, 32'h0, 1'b0, st, f, fv, sr, h);
    total++; if (h !== 1'b0 || st != 5) begin bad++;
      $display("FAIL miss_stalls: got %0d (hung=%b) expected 5", st, h); end
    total++; if ({f, fv} !== {1'b1, 32'hDEADBEEF}) begin bad++;
      $display("FAIL miss_fill: got fill=%b data=%h expected 1 deadbeef", f, fv); end
  endtask

  task automatic test_back_to_back_store();
    int st; logic f, sr, h; logic [31:0] fv, d2;
    auto_mode = 1'b1; lat = 2; d2 = $urandom;
    log_q.delete();
    run_op(2, 32'h80, 32'h12345678, 1'b1, st, f, fv, sr, h);
    total++; if (h !== 1'b0 || st != 0) begin bad++; $display("FAIL store1_stall: got %0d expected 0", st); end
    run_op(2, 32'h84, d2, 1'b0, st, f, fv, sr, h);
    total++; if (h !== 1'b0 || st != 1) begin bad++; $display("FAIL store2_stall: got %0d expected 1", st); end
    drain(h);
    total++; if (h !== 1'b0 || log_q.size() != 2) begin bad++;
      $display("FAIL store_log_size: got %0d expected 2", log_q.size()); end
    else begin
      total++; if (log_q[0] !== {1'b1, 32'h80, 32'h12345678} || log_q[1] !== {1'b1, 32'h84, d2}) begin bad++;
        $display("FAIL store_order: got %h %h expected 1/80/12345678 1/84/%h", log_q[0], log_q[1], d2); end
    end
  endtask

  task automatic test_store_then_load();
    int st; logic f, sr, h; logic [31:0] fv, d;
    auto_mode = 1'b1; lat = 2; d = $urandom;
    ram_mem[32'h90 >> 2] = ~d;
    log_q.delete();
    run_op(2, 32'h90, d, 1'b0, st, f, fv, sr, h);
    run_op(1, 32'h90, 32'h0, 1'b0, st, f, fv, sr, h);
    total++; if ({h, f, fv} !== {2'b01, d} || st != 5) begin bad++;
      $display("FAIL raw_fill: got data=%h stalls=%0d expected %h 5", fv, st, d); end
    total++; if (log_q.size() != 2 || log_q[0] !== {1'b1, 32'h90, d} || log_q[1] !== {1'b0, 32'h90, d}) begin bad++;
      $display("FAIL raw_order: got %0d xacts, first=%h expected write then read of 90", log_q.size(), log_q[0]); end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem[16];
    int st, nst, wrs, diff; logic f, sr, h; logic [31:0] fv, a, d;
    int kind, idx, r;
    auto_mode = 1'b1; nst = 0; diff = 0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; ram_mem[256 + i] = ref_mem[i]; end
    log_q.delete();
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 4) ? 2 : (r < 8) ? 1 : 0;
      idx = $urandom_range(0, 15);
      a = 32'h400 + idx * 4 + $urandom_range(0, 3);
      d = $urandom;
      lat = $urandom_range(1, 4);
      if (kind == 1 && $urandom_range(0, 1) == 1) begin
        run_op(1, a, 32'h0, 1'b1, st, f, fv, sr, h);
        total++; if (h !== 1'b0 || st != 0) begin bad++; $display("FAIL rnd_hit_stall: got %0d expected 0", st); end
      end else if (kind == 1) begin
        run_op(1, a, 32'h0, 1'b0, st, f, fv, sr, h);
        total++; if ({h, f, fv} !== {2'b01, ref_mem[idx]}) begin bad++;
          $display("FAIL rnd_miss_data: addr %h got %h expected %h", a, fv, ref_mem[idx]); end
      end else if (kind == 2) begin
        run_op(2, a, d, $urandom_range(0, 1) == 1, st, f, fv, sr, h);
        ref_mem[idx] = d; nst++;
        total++; if (h !== 1'b0 || st > 4) begin bad++; $display("FAIL rnd_store_stall: got %0d expected <=4", st); end
      end else begin
        run_op(0, a, d, 1'b0, st, f, fv, sr, h);
      end
    end
    drain(h);
    wrs = 0;
    foreach (log_q[i]) if (log_q[i].we) wrs++;
    for (int i = 0; i < 16; i++) if (ram_mem[256 + i] !== ref_mem[i]) diff++;
    total++; if (h !== 1'b0 || diff != 0) begin bad++; $display("FAIL rnd_mem: got %0d differing words expected 0", diff); end
    total++; if (wrs != nst) begin bad++; $display("FAIL rnd_writes: got %0d expected %0d", wrs, nst); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rnd_err: got %b expected 0", bus.err); end
    total++; if (stab_viol != 0) begin bad++; $display("FAIL req_stable: got %0d changes expected 0", stab_viol); end
  endtask

  task automatic test_timeout();
    logic h;
    do_reset();
    auto_mode = 1'b0; manual_ack = 1'b0;
    @(posedge clk); #1 bus.load = 1'b1; bus.addr = 32'h300; bus.cache_hit = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 4) begin
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL timeout_early: got err=%b expected 0", bus.err); end
      end
    end
    total++; if ({bus.err, bus.ram_req} !== 2'b11) begin bad++;
      $display("FAIL timeout_err: got err,req=%b expected 11", {bus.err, bus.ram_req}); end
    manual_ack = 1'b1;
    @(posedge clk); #3 manual_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.err, bus.cache_fill} !== 2'b11) begin bad++;
      $display("FAIL timeout_sticky: got err,fill=%b expected 11", {bus.err, bus.cache_fill}); end
    @(posedge clk); #1 bus.cache_hit = 1'b1;
    @(posedge clk); #1 bus.load = 1'b0;
    do_reset();
    auto_mode = 1'b1; lat = 1;
    @(negedge clk);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b expected 0", bus.err); end
    @(posedge clk); #1 bus.load = 1'b1; bus.store = 1'b1; bus.addr = 32'h500; bus.store_word = 32'hA5A5A5A5;
    @(negedge clk);
    total++; if ({bus.stall, bus.cache_wen, bus.cache_fill} !== 3'b010) begin bad++;
      $display("FAIL ld_st_as_store: got stall,wen,fill=%b expected 010", {bus.stall, bus.cache_wen, bus.cache_fill}); end
    @(posedge clk); #1 bus.load = 1'b0; bus.store = 1'b0;
    @(negedge clk);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ld_st_err: got %b expected 1", bus.err); end
    drain(h);
    total++; if (h !== 1'b0 || ram_mem[32'h500 >> 2] !== 32'hA5A5A5A5) begin bad++;
      $display("FAIL ld_st_write: got %h expected a5a5a5a5", ram_mem[32'h500 >> 2]); end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_load_miss();
    test_back_to_back_store();
    test_store_then_load();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
